// File: rtl/sirius_axi_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
package sirius_axi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned ID_W   = 4;

  // Requester indices into the request/pick vectors
  localparam int unsigned REQ_INST = 0;
  localparam int unsigned REQ_DATA = 1;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // Registered AR payload of the burst currently owned
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } ar_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; on a tie the requester not granted last wins.
module rr_arb2
  import sirius_axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  // One-hot pick; a lone request always wins
  always_comb begin
    pick = 2'b00;
    if (req[REQ_INST] && req[REQ_DATA]) begin
      if (last == 1'(REQ_INST)) begin
        pick[REQ_DATA] = 1'b1;
      end else begin
        pick[REQ_INST] = 1'b1;
      end
    end else begin
      pick = req;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI AR/R channel pair between instruction and data refill paths.
// One burst outstanding; owner keeps the channel until the rlast beat.
module axi_read_arbiter
  import sirius_axi_pkg::*;
#(
  parameter logic [ID_W-1:0] ID_INST = 4'd0,
  parameter logic [ID_W-1:0] ID_DATA = 4'd1
) (
  input  logic              clk,
  input  logic              rst,
  // instruction requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic              i_rlast,
  // data requester
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LEN_W-1:0]  d_len,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_rlast,
  // shared beat data
  output logic [DATA_W-1:0] rdata_o,
  // AXI AR channel
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  // AXI R channel
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // sticky protocol error
  output logic              proto_err
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              owner_q;      // requester index of the current burst
  logic              last_q;       // requester index of the last completed burst
  ar_req_t           ar_q;
  ar_req_t           sel_req;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic              proto_err_q;
  logic [1:0]        req;
  logic [1:0]        pick;
  logic              start;
  logic              ar_hs;
  logic              beat;
  logic              beat_err;

  // Gather requests into a vector indexed by requester
  always_comb begin
    req           = 2'b00;
    req[REQ_INST] = i_req;
    req[REQ_DATA] = d_req;
  end

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_q),
    .pick (pick)
  );

  // AR payload of the picked requester
  always_comb begin
    sel_req = '{id: ID_INST, addr: i_addr, len: i_len};
    if (pick[REQ_DATA]) begin
      sel_req = '{id: ID_DATA, addr: d_addr, len: d_len};
    end
  end

  assign start = (state_q == ST_IDLE) && (|req);
  assign ar_hs = (state_q == ST_ADDR) && arready;
  assign beat  = (state_q == ST_DATA) && rvalid;

  // Beat is malformed if id, terminal position or response is wrong
  always_comb begin
    beat_err = 1'b0;
    if (rid != ar_q.id) begin
      beat_err = 1'b1;
    end
    if (rlast && (beat_cnt_q != ar_q.len)) begin
      beat_err = 1'b1;
    end
    if (!rlast && (beat_cnt_q == ar_q.len)) begin
      beat_err = 1'b1;
    end
    if (rresp != AXI_RESP_OKAY) begin
      beat_err = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (|req) state_d = ST_ADDR;
      ST_ADDR: if (arready) state_d = ST_DATA;
      ST_DATA: if (rvalid && rlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Ownership, AR payload, beat counter and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= 1'(REQ_INST);
      last_q      <= 1'(REQ_INST);
      ar_q        <= '0;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (start) begin
        owner_q <= pick[REQ_DATA];
        ar_q    <= sel_req;
      end
      if (ar_hs) begin
        beat_cnt_q <= '0;
      end else if (beat && (beat_cnt_q != '1)) begin
        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
      end
      if (beat && beat_err) begin
        proto_err_q <= 1'b1;
      end
      if (beat && rlast) begin
        last_q <= owner_q;
      end
    end
  end

  // Channel handshakes and steering of grants and beats to the owner
  always_comb begin
    arvalid  = 1'b0;
    rready   = 1'b0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rlast  = 1'b0;
    d_rlast  = 1'b0;
    rdata_o  = '0;
    unique case (state_q)
      ST_ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          if (owner_q == 1'(REQ_DATA)) d_gnt = 1'b1;
          else                         i_gnt = 1'b1;
        end
      end
      ST_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_o = rdata;
          if (owner_q == 1'(REQ_DATA)) begin
            d_rvalid = 1'b1;
            d_rlast  = rlast;
          end else begin
            i_rvalid = 1'b1;
            i_rlast  = rlast;
          end
        end
      end
      default: ;
    endcase
  end

  assign arid      = ar_q.id;
  assign araddr    = ar_q.addr;
  assign arlen     = ar_q.len;
  assign arsize    = AXI_SIZE_4B;
  assign arburst   = AXI_BURST_INCR;
  assign proto_err = proto_err_q;

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares the single AXI read-address/read-data channel pair of the CPU top between the instruction-fetch refill path and the data refill path inside the memory subsystem. Accepts one burst request at a time from either requester, drives AR, steers the R beats back to the owning requester, and holds ownership until the last beat. Fairness is two-way round-robin. It sits between the cache/MMU request logic and the top-level AXI `ar*`/`r*` ports.

## Interface
Parameters:
- `ID_INST`, 4'd0, ARID used for instruction bursts
- `ID_DATA`, 4'd1, ARID used for data bursts

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `i_req`  in  1  instruction burst request; held until `i_gnt`
- `i_addr`  in  32  instruction burst start address
- `i_len`  in  8  instruction burst length minus 1 (AXI encoding)
- `i_gnt`  out  1  one-cycle pulse: AR handshake done for instruction request
- `i_rvalid`  out  1  beat valid to instruction requester
- `i_rlast`  out  1  last beat to instruction requester
- `d_req`, `d_addr`, `d_len`, `d_gnt`, `d_rvalid`, `d_rlast`: same as `i_*`, for data
- `rdata_o`  out  32  beat data, shared by both requesters (qualify with `*_rvalid`)
- `arid`  out  4, `araddr`  out  32, `arlen`  out  8, `arsize`  out  3, `arburst`  out  2, `arvalid`  out  1, `arready`  in  1: AXI AR channel
- `rid`  in  4, `rdata`  in  32, `rresp`  in  2, `rlast`  in  1, `rvalid`  in  1, `rready`  out  1: AXI R channel
- `proto_err`  out  1  sticky: rid mismatch, early/late `rlast`, or non-OKAY `rresp`

## Operation
- States: IDLE, ADDR, DATA. One burst outstanding at most.
- IDLE: if any request, pick owner via round-robin, register `arid/araddr/arlen` from owner, go ADDR. Both requesting: grant the one not granted last; `last` resets to inst, so data wins the first tie.
- ADDR: `arvalid`=1, AR fields stable. On `arready`: pulse owner's `*_gnt`, clear beat counter, go DATA.
- DATA: `rready`=1. Each `rvalid` beat: owner's `*_rvalid`=1, `rdata_o`=`rdata`, owner's `*_rlast`=`rlast`; counter increments. On `rlast` beat go IDLE and update `last`.
- `arsize` constant 3'b010, `arburst` constant 2'b01 (INCR).
- Error checks on each accepted beat set `proto_err`: `rid`≠owner ID; `rlast`=1 with count≠`arlen`; `rlast`=0 with count=`arlen`; `rresp`≠2'b00. Beats are still forwarded; only `rlast` ends the burst. `proto_err` is cleared only by reset.
- Counter is 8 bits; comparison against registered `arlen`, no wrap beyond 255.
- Non-owner `*_rvalid`, `*_rlast`, `*_gnt` are always 0.

## Timing
- Reset (async): state IDLE, `arvalid`=0, `rready`=0, `arid/araddr/arlen`=0, all `*_gnt/*_rvalid/*_rlast`=0, `proto_err`=0, `last`=inst. Reset mid-burst abandons it; no beats forwarded after reset.
- Request seen in IDLE at cycle 0 → `arvalid` at cycle 1. `*_gnt` in the cycle `arvalid&&arready`.
- R path is combinational: beat forwarded in same cycle as `rvalid&&rready`.
- After `rlast` beat in cycle N: IDLE in N+1, next `arvalid` earliest N+2.
- Request dropped before `*_gnt` is protocol violation by requester; arbiter still completes the burst.
- `*_gnt` and a forwarded beat never in same cycle.

## Structure
- Package `sirius_axi_pkg`: state enum, `AXI_SIZE_4B`, `AXI_BURST_INCR`, `AXI_RESP_OKAY`, requester index constants (`REQ_INST`=0, `REQ_DATA`=1).
- Sub-module `rr_arb2`: two-request round-robin picker (inputs `req[1:0]`, `last`; output one-hot `pick`), purely combinational. Rest in `axi_read_arbiter`.

## Test plan
- Single inst request addr 0x1FC0_0000 len 7, `arready` at once, 8 beats, `rlast` on 8th → `arid`=0, `arlen`=7, `i_gnt` cycle 1, 8 `i_rvalid`, `i_rlast` on 8th, `d_*` silent, `proto_err`=0.
- Both request same cycle after reset (d 0x8000_0040 len 3, i 0xBFC0_0000 len 7) → data first (`arid`=1), then inst; repeat tie → order alternates.
- `arready` held low 5 cycles → `arvalid` and AR fields stable all 5 cycles, `d_gnt` only on handshake.
- `rvalid` gaps between beats and `rid`=2 on one beat → beats still forwarded, `proto_err` rises and stays 1.
- Len 3 burst with `rlast` on beat 2 → burst ends, `proto_err`=1; next request issued normally.
- Assert `rst` during DATA after 2 of 8 beats → next cycle `rready`=0, `arvalid`=0, no further `*_rvalid`; after release new request proceeds from IDLE.
